// File: rtl/matrix_result_scanner_pkg.sv
// Shared definitions for the result-matrix scanner: default sizes,
// scan FSM state encoding and width helpers.
package matrix_result_scanner_pkg;

    localparam int DEF_N  = 3;
    localparam int DEF_DW = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        FETCH     = 3'd2,
        LATCH     = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Address width for an n*n matrix (at least one bit).
    function automatic int idx_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Row/column index width for an n*n matrix (at least one bit).
    function automatic int rc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_result_scanner_if.sv
// Control, result-memory and display signals of the scanner.
// The scanner uses the master view; memory/display/control side uses slave.
interface matrix_result_scanner_if
    import matrix_result_scanner_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
);
    localparam int AW = idx_w(N);
    localparam int RW = rc_w(N);

    logic          start;
    logic          stop;
    logic          result_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] disp_value;
    logic [RW-1:0] disp_row;
    logic [RW-1:0] disp_col;
    logic          disp_valid;
    logic          busy;
    logic          done;

    modport master (
        input  start, stop, result_valid, rd_data,
        output rd_addr, disp_value, disp_row, disp_col, disp_valid, busy, done
    );

    modport slave (
        output start, stop, result_valid, rd_data,
        input  rd_addr, disp_value, disp_row, disp_col, disp_valid, busy, done
    );

endinterface

// File: rtl/matrix_result_scanner_tick_sync.sv
// Brings an asynchronous slow level into the clk domain and turns each
// rising edge into a one-cycle step. Also usable for push buttons.
module matrix_result_scanner_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic step
);
    logic sync_p0;
    logic sync_p1;
    logic edge_p2;

    // Two-flop synchroniser followed by the previous-value register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            edge_p2 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            edge_p2 <= sync_p1;
        end
    end

    assign step = sync_p1 & ~edge_p2;

endmodule

// File: rtl/matrix_result_scanner.sv
// Walks the N x N result matrix in row-major order, one element per
// slow_clk rising edge, and presents each element with its row/column.
module matrix_result_scanner
    import matrix_result_scanner_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int DW   = DEF_DW,
    parameter int LOOP = 0
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic                    slow_clk,
    matrix_result_scanner_if.master bus
);
    localparam int AW = idx_w(N);
    localparam int RW = rc_w(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);
    localparam logic [RW-1:0] LAST_COL = RW'(N - 1);

    state_t        state_q;
    state_t        state_d;
    logic          step;
    logic [AW-1:0] idx;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [DW-1:0] value_q;
    logic [RW-1:0] row_q;
    logic [RW-1:0] col_q;
    logic          valid_q;
    logic          is_last;

    matrix_result_scanner_tick_sync u_tick_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (slow_clk),
        .step  (step)
    );

    assign is_last = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.start && bus.result_valid) state_d = WAIT_TICK;
            WAIT_TICK: if (step) state_d = FETCH;
            FETCH:     state_d = LATCH;
            LATCH:     state_d = (is_last && LOOP == 0) ? DONE : WAIT_TICK;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (bus.stop) state_d = IDLE;
    end

    // Element index and row/column counters; idx doubles as the read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (!bus.stop) begin
            if (state_q == IDLE && bus.start && bus.result_valid) begin
                idx <= '0;
                row <= '0;
                col <= '0;
            end else if (state_q == LATCH) begin
                if (is_last) begin
                    if (LOOP != 0) begin
                        idx <= '0;
                        row <= '0;
                        col <= '0;
                    end
                end else begin
                    idx <= idx + 1'b1;
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

    // Display registers load as FETCH hands over to LATCH, so the new element
    // and its valid pulse are visible during the LATCH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == FETCH && !bus.stop) begin
                value_q <= bus.rd_data;
                row_q   <= row;
                col_q   <= col;
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.rd_addr    = idx;
    assign bus.disp_value = value_q;
    assign bus.disp_row   = row_q;
    assign bus.disp_col   = col_q;
    assign bus.disp_valid = valid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);

endmodule
